// File: rtl/usb_tx_pkt_encoder_pkg.sv
// Shared types and constants for the USB TX packet encoder: FSM states,
// packet codes, PID nibbles and CRC16 parameters.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_CRC_LO,
    ST_CRC_HI,
    ST_EOP
  } state_t;

  typedef enum logic [2:0] {
    PKT_DATA0 = 3'd1,
    PKT_ACK   = 3'd2,
    PKT_NAK   = 3'd3,
    PKT_STALL = 3'd4,
    PKT_DATA1 = 3'd5
  } pkt_t;

  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  // Reflected form of poly 0x8005, for LSB-first byte processing
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

  function automatic logic pkt_legal(input logic [2:0] code);
    return (code >= 3'd1) && (code <= 3'd5);
  endfunction

  function automatic logic pkt_is_data(input pkt_t pkt);
    return (pkt == PKT_DATA0) || (pkt == PKT_DATA1);
  endfunction

  // PID byte goes out as {check nibble, pid nibble}
  function automatic logic [7:0] pid_byte(input pkt_t pkt);
    logic [3:0] pid4;
    case (pkt)
      PKT_DATA0: pid4 = PID_DATA0;
      PKT_DATA1: pid4 = PID_DATA1;
      PKT_ACK:   pid4 = PID_ACK;
      PKT_NAK:   pid4 = PID_NAK;
      default:   pid4 = PID_STALL;
    endcase
    return {~pid4, pid4};
  endfunction

endpackage

// File: rtl/usb_tx_pkt_encoder_if.sv
// Handshake/byte bus between the packet encoder and its environment
// (packet requester, TX FIFO and NRZI/bit-stuff serializer).
interface usb_tx_pkt_encoder_if #(
  parameter int OCC_W = 7
);
  logic             begin_packet;
  logic [2:0]       tx_packet;
  logic [7:0]       tx_packet_data;
  logic [OCC_W-1:0] buffer_occupancy;
  logic             rollover_flag;
  logic [7:0]       shift_data;
  logic             load_byte;
  logic             get_tx_data;
  logic             is_eop;
  logic             end_packet;
  logic             busy;
  logic             pkt_err;

  modport master (
    output begin_packet, tx_packet, tx_packet_data, buffer_occupancy, rollover_flag,
    input  shift_data, load_byte, get_tx_data, is_eop, end_packet, busy, pkt_err
  );

  modport slave (
    input  begin_packet, tx_packet, tx_packet_data, buffer_occupancy, rollover_flag,
    output shift_data, load_byte, get_tx_data, is_eop, end_packet, busy, pkt_err
  );
endinterface

// File: rtl/usb_tx_pkt_encoder_crc16.sv
// USB CRC16 accumulator: one byte per enabled cycle, LSB-first, reflected register.
module usb_crc16
  import usb_tx_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  logic [15:0] crc_next;

  always_comb begin
    crc_next = crc ^ {8'h00, data};
    for (int unsigned i = 0; i < 8; i++) begin
      crc_next = crc_next[0] ? ((crc_next >> 1) ^ CRC16_POLY_REFL) : (crc_next >> 1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      crc <= CRC16_INIT;
    end else if (clear) begin
      crc <= CRC16_INIT;
    end else if (enable) begin
      crc <= crc_next;
    end
  end

endmodule

// File: rtl/usb_tx_pkt_encoder.sv
// Byte-level USB TX packet sequencer: SYNC, PID, FIFO payload, CRC16, EOP,
// one byte handed to the serializer per rollover.
module usb_tx_pkt_encoder
  import usb_tx_pkg::*;
#(
  parameter int          OCC_W       = 7,
  parameter int          MAX_PAYLOAD = 64,
  parameter int          EOP_CYC     = 2,
  parameter logic [7:0]  SYNC_BYTE   = 8'h80
) (
  input logic                clk,
  input logic                n_rst,
  usb_tx_pkt_encoder_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_PAYLOAD + 1);
  localparam int EOP_W = (EOP_CYC > 1) ? $clog2(EOP_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_PAYLOAD);
  localparam logic [EOP_W-1:0] EOP_LAST = EOP_W'(EOP_CYC - 1);

  state_t           state;
  pkt_t             pkt_q;
  logic [CNT_W-1:0] count;
  logic [EOP_W-1:0] eop_cnt;
  logic [15:0]      crc;
  logic [OCC_W-1:0] occ;

  logic [7:0] shift_q;
  logic       load_q, get_q, eop_q, end_q, err_q;

  logic take_byte, start_ok, crc_clear, crc_en;

  assign occ = bus.buffer_occupancy;

  always_comb begin
    take_byte = (occ != '0) && (count < CNT_MAX);
    start_ok  = (state == ST_IDLE) && bus.begin_packet && pkt_legal(bus.tx_packet);
    crc_clear = start_ok;
    // CRC absorbs the FIFO head on the same edge the byte is loaded and popped
    crc_en    = bus.rollover_flag && take_byte &&
                ((state == ST_DATA) || ((state == ST_PID) && pkt_is_data(pkt_q)));
  end

  usb_crc16 u_crc (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (crc_clear),
    .enable (crc_en),
    .data   (bus.tx_packet_data),
    .crc    (crc)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= ST_IDLE;
      pkt_q   <= PKT_DATA0;
      count   <= '0;
      eop_cnt <= '0;
      shift_q <= '0;
      load_q  <= 1'b0;
      get_q   <= 1'b0;
      eop_q   <= 1'b0;
      end_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      load_q <= 1'b0;
      get_q  <= 1'b0;
      end_q  <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.begin_packet) begin
            if (pkt_legal(bus.tx_packet)) begin
              pkt_q   <= pkt_t'(bus.tx_packet);
              count   <= '0;
              state   <= ST_SYNC;
              shift_q <= SYNC_BYTE;
              load_q  <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_SYNC: begin
          if (bus.rollover_flag) begin
            state   <= ST_PID;
            shift_q <= pid_byte(pkt_q);
            load_q  <= 1'b1;
          end
        end
        ST_PID, ST_DATA: begin
          if (bus.rollover_flag) begin
            if ((state == ST_PID) && !pkt_is_data(pkt_q)) begin
              state   <= ST_EOP;
              eop_q   <= 1'b1;
              shift_q <= 8'hFF;
              eop_cnt <= '0;
              end_q   <= (EOP_LAST == '0);
            end else if (take_byte) begin
              state   <= ST_DATA;
              get_q   <= 1'b1;
              shift_q <= bus.tx_packet_data;
              load_q  <= 1'b1;
              count   <= count + 1'b1;
            end else begin
              state   <= ST_CRC_LO;
              shift_q <= ~crc[7:0];
              load_q  <= 1'b1;
            end
          end
        end
        ST_CRC_LO: begin
          if (bus.rollover_flag) begin
            state   <= ST_CRC_HI;
            shift_q <= ~crc[15:8];
            load_q  <= 1'b1;
          end
        end
        ST_CRC_HI: begin
          if (bus.rollover_flag) begin
            state   <= ST_EOP;
            eop_q   <= 1'b1;
            shift_q <= 8'hFF;
            eop_cnt <= '0;
            end_q   <= (EOP_LAST == '0);
          end
        end
        ST_EOP: begin
          if (eop_cnt == EOP_LAST) begin
            state <= ST_IDLE;
            eop_q <= 1'b0;
          end else begin
            eop_cnt <= eop_cnt + 1'b1;
            end_q   <= ((eop_cnt + 1'b1) == EOP_LAST);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.shift_data  = shift_q;
  assign bus.load_byte   = load_q;
  assign bus.get_tx_data = get_q;
  assign bus.is_eop      = eop_q;
  assign bus.end_packet  = end_q;
  assign bus.busy        = (state != ST_IDLE);
  assign bus.pkt_err     = err_q;

endmodule
